// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch lap bank: lap record layout and the
// lap_bank_ctrl FSM state encoding.
package stopwatch_pkg;

    localparam int unsigned LAP_W = 28;

    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] minute;
        logic [5:0] second;
        logic [9:0] m_sec;
    } lap_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP,
        ST_CLEAR
    } lap_state_t;

endpackage

// File: rtl/lap_ram.sv
// Single-port synchronous lap RAM, DEPTH x W, registered read (1-cycle latency).
// Contents are not reset; the controller wipes them with a CLEAR sweep.
module lap_ram #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned W     = 28
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port and registered read share one address.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lap_bank_ctrl.sv
// Lap bank controller: circular lap store with SAVE / RETRIEVE / CLEAR.
// Build option: LAP_OVERWRITE_EN -- when defined, a SAVE while full overwrites
// the oldest lap; when undefined, it is dropped and the sticky overflow flag set.
module lap_bank_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          save_req,
    input  logic          retrieve_req,
    input  logic          clear_req,
    input  logic [17:0]   epoch,
    input  logic [9:0]    m_epoch,
    output logic [17:0]   lap_epoch,
    output logic [9:0]    lap_m_epoch,
    output logic [AW-1:0] lap_index,
    output logic          lap_valid,
    output logic [AW:0]   lap_count,
    output logic          full,
    output logic          overflow,
    output logic          reg_busy
);

    lap_state_t state_q, state_d;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_cur;
    logic [AW-1:0] clr_addr;
    lap_t          save_data;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    lap_t          ram_wdata;
    lap_t          ram_rdata;

    logic [AW-1:0] rd_eff;
    logic [AW:0]   rd_next;
    logic [AW-1:0] rd_addr;
    logic          write_ok;

    assign full     = (lap_count == (AW+1)'(DEPTH));
    assign reg_busy = (state_q != ST_IDLE);

    // Read position is relative to the oldest entry; out-of-range falls back to 0.
    always_comb begin
        rd_eff  = ({1'b0, rd_cur} >= lap_count) ? '0 : rd_cur;
        rd_next = {1'b0, rd_eff} + (AW+1)'(1);
        rd_addr = wr_ptr - lap_count[AW-1:0] + rd_eff;
`ifdef LAP_OVERWRITE_EN
        write_ok = 1'b1;
`else
        write_ok = !full;
`endif
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and RAM port control.
    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end else if (save_req) begin
                    state_d = ST_WRITE;
                end else if (retrieve_req && (lap_count != '0)) begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                ram_we    = write_ok;
                ram_addr  = wr_ptr;
                ram_wdata = save_data;
                state_d   = ST_IDLE;
            end
            ST_READ: begin
                ram_addr = rd_addr;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = clr_addr;
                if (clr_addr == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointers, counters, captured SAVE data and retrieved-lap outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_cur      <= '0;
            clr_addr    <= '0;
            lap_count   <= '0;
            overflow    <= 1'b0;
            save_data   <= '0;
            lap_epoch   <= '0;
            lap_m_epoch <= '0;
            lap_index   <= '0;
            lap_valid   <= 1'b0;
        end else begin
            lap_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    save_data <= {epoch, m_epoch};
                end
                ST_WRITE: begin
                    if (write_ok) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (!full) begin
                            lap_count <= lap_count + (AW+1)'(1);
                        end
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                ST_RESP: begin
                    lap_epoch   <= {ram_rdata.hour, ram_rdata.minute, ram_rdata.second};
                    lap_m_epoch <= ram_rdata.m_sec;
                    lap_index   <= rd_eff;
                    lap_valid   <= 1'b1;
                    rd_cur      <= (rd_next >= lap_count) ? '0 : rd_next[AW-1:0];
                end
                ST_CLEAR: begin
                    clr_addr    <= clr_addr + AW'(1);
                    wr_ptr      <= '0;
                    rd_cur      <= '0;
                    lap_count   <= '0;
                    overflow    <= 1'b0;
                    lap_epoch   <= '0;
                    lap_m_epoch <= '0;
                    lap_index   <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    lap_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (LAP_W)
    ) u_lap_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
